// File: rtl/gpio_in_filter.sv
// Per-pin pad synchroniser and debouncer producing filtered levels and rise/fall pulses.
// Define GPIO_IN_FILTER_GLITCH_STATS_EN to build the saturating rejected-glitch counter.
module gpio_in_filter #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] pins_i,
  input  logic [WIDTH-1:0] filter_en_i,
  input  logic [CNT_W-1:0] debounce_len_i,
  output logic [WIDTH-1:0] pins_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             changed_o,
  output logic [15:0]      glitch_cnt_o
);

  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [CNT_W-1:0] cnt [WIDTH];

  assign sync = sync_p[SYNC_STAGES-1];

  // Synchroniser chain, then per-pin debounce state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      filt <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      sync_p[0] <= pins_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
      for (int i = 0; i < WIDTH; i++) begin
        rise[i] <= 1'b0;
        fall[i] <= 1'b0;
        if (!filter_en_i[i]) begin
          filt[i] <= sync[i];
          cnt[i]  <= '0;
          rise[i] <= sync[i] & ~filt[i];
          fall[i] <= ~sync[i] & filt[i];
        end else if (sync[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] >= debounce_len_i) begin
          // Counter never passes the threshold, so it cannot wrap
          filt[i] <= sync[i];
          cnt[i]  <= '0;
          rise[i] <= sync[i];
          fall[i] <= ~sync[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign pins_o    = filt;
  assign rise_o    = rise;
  assign fall_o    = fall;
  assign changed_o = |(rise | fall);

`ifdef GPIO_IN_FILTER_GLITCH_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        abandon;
  logic [15:0] glitch_cnt;

  // A candidate change is abandoned when the level returns before acceptance
  always_comb begin
    abandon = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (filter_en_i[i] && (sync[i] == filt[i]) && (cnt[i] != '0)) abandon = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) glitch_cnt <= '0;
    else if (abandon) glitch_cnt <= sat_inc16(glitch_cnt);
  end

  assign glitch_cnt_o = glitch_cnt;
`else
  assign glitch_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed scoreboard bench for gpio_in_filter: stimulus pushes the hand-computed
// outputs expected after each clock edge, a monitor pops and compares them.
module tb_gpio_in_filter;

  logic        clk;
  logic        rst_n;
  logic [31:0] pins;
  logic [31:0] en;
  logic [7:0]  len;
  logic [31:0] pins_o;
  logic [31:0] rise_o;
  logic [31:0] fall_o;
  logic        changed_o;
  logic [15:0] glitch_cnt_o;

`ifdef GPIO_IN_FILTER_GLITCH_STATS_EN
  localparam logic [15:0] G1 = 16'd1;
`else
  localparam logic [15:0] G1 = 16'd0;
`endif

  typedef struct {
    logic [31:0] pins;
    logic [31:0] rise;
    logic [31:0] fall;
    logic [15:0] glitch;
    string       name;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  gpio_in_filter dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .pins_i         (pins),
    .filter_en_i    (en),
    .debounce_len_i (len),
    .pins_o         (pins_o),
    .rise_o         (rise_o),
    .fall_o         (fall_o),
    .changed_o      (changed_o),
    .glitch_cnt_o   (glitch_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are settled at the falling edge after each rising edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic ec;
      e  = sb.pop_front();
      ec = |(e.rise | e.fall);
      checks++;
      if (pins_o !== e.pins || rise_o !== e.rise || fall_o !== e.fall ||
          changed_o !== ec || glitch_cnt_o !== e.glitch) begin
        errors++;
        $display("FAIL %s @%0t: got pins=%h rise=%h fall=%h chg=%b glitch=%h, expected pins=%h rise=%h fall=%h chg=%b glitch=%h",
                 e.name, $time, pins_o, rise_o, fall_o, changed_o, glitch_cnt_o,
                 e.pins, e.rise, e.fall, ec, e.glitch);
      end
    end
  end

  task automatic cyc(input logic [31:0] p, input logic [31:0] ep, input logic [31:0] er,
                     input logic [31:0] ef, input logic [15:0] eg, input string nm);
    exp_t e;
    pins     = p;
    e.pins   = ep;
    e.rise   = er;
    e.fall   = ef;
    e.glitch = eg;
    e.name   = nm;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en    = 32'hFFFF_FFFF;
    len   = 8'd1;
    pins  = 32'hFFFF_FFFF;
    #1;

    // Reset hold and release: all pins accepted together after 2+1+1 edges
    repeat (3) cyc(32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 16'h0, "reset_hold");
    rst_n = 1'b1;
    repeat (3) cyc(32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 16'h0, "reset_release");
    cyc(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 16'h0, "reset_first_accept");
    cyc(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 16'h0, "reset_steady");

    // Zero-length debounce: accepted on the first differing cycle
    len = 8'd0;
    repeat (2) cyc(32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 16'h0, "len0_wait");
    cyc(32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 16'h0, "len0_accept");
    cyc(32'h0, 32'h0, 32'h0, 32'h0, 16'h0, "len0_steady");

    // Latency with len=3: visible 6 edges after the step
    len = 8'd3;
    repeat (5) cyc(32'h20, 32'h0, 32'h0, 32'h0, 16'h0, "lat_wait");
    cyc(32'h20, 32'h20, 32'h20, 32'h0, 16'h0, "lat_accept");
    cyc(32'h20, 32'h20, 32'h0, 32'h0, 16'h0, "lat_pulse_end");

    // Glitch: bit 0 high for 3 cycles is rejected
    repeat (3) cyc(32'h21, 32'h20, 32'h0, 32'h0, 16'h0, "glitch_high");
    repeat (2) cyc(32'h20, 32'h20, 32'h0, 32'h0, 16'h0, "glitch_low");
    cyc(32'h20, 32'h20, 32'h0, 32'h0, G1, "glitch_count");
    cyc(32'h20, 32'h20, 32'h0, 32'h0, G1, "glitch_hold");

    // Bypass: 3-edge latency regardless of len, single-cycle pulse passes through
    en  = 32'h0;
    len = 8'hFF;
    repeat (2) cyc(32'hA5A5_5A5A, 32'h20, 32'h0, 32'h0, G1, "byp_wait");
    cyc(32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'h20, G1, "byp_accept");
    cyc(32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'h0, 32'h0, G1, "byp_steady");
    cyc(32'hA5A5_5A52, 32'hA5A5_5A5A, 32'h0, 32'h0, G1, "byp_pulse_in");
    cyc(32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'h0, 32'h0, G1, "byp_pulse_back");
    cyc(32'hA5A5_5A5A, 32'hA5A5_5A52, 32'h0, 32'h8, G1, "byp_pulse_fall");
    cyc(32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'h8, 32'h0, G1, "byp_pulse_rise");
    cyc(32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'h0, 32'h0, G1, "byp_pulse_end");

    // Threshold lowered from 10 to 2 after 5 differing cycles
    en  = 32'hFFFF_FFFF;
    len = 8'd10;
    repeat (7) cyc(32'hA5A5_5ADA, 32'hA5A5_5A5A, 32'h0, 32'h0, G1, "thr_count");
    len = 8'd2;
    cyc(32'hA5A5_5ADA, 32'hA5A5_5ADA, 32'h80, 32'h0, G1, "thr_accept");
    cyc(32'hA5A5_5ADA, 32'hA5A5_5ADA, 32'h0, 32'h0, G1, "thr_steady");

    // Reset in the middle of a count
    len = 8'd10;
    repeat (4) cyc(32'h0, 32'hA5A5_5ADA, 32'h0, 32'h0, G1, "rmid_count");
    rst_n = 1'b0;
    repeat (2) cyc(32'h0, 32'h0, 32'h0, 32'h0, 16'h0, "rmid_reset");
    rst_n = 1'b1;
    repeat (2) cyc(32'h0, 32'h0, 32'h0, 32'h0, 16'h0, "rmid_quiet");

    // Fresh count after reset: len=2 accepts on edge 5
    len = 8'd2;
    repeat (4) cyc(32'h2, 32'h0, 32'h0, 32'h0, 16'h0, "post_rst_wait");
    cyc(32'h2, 32'h2, 32'h2, 32'h0, 16'h0, "post_rst_accept");
    cyc(32'h2, 32'h2, 32'h0, 32'h0, 16'h0, "post_rst_steady");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_in_filter.md
# gpio_in_filter

Input-conditioning stage that sits directly upstream of the GPIO peripheral's input register. It synchronises asynchronous pad levels into the system clock domain and debounces each pin with a programmable stability window. It produces clean per-pin levels plus single-cycle rise/fall event pulses for the GPIO input path and for future interrupt logic.

## Interface
- `WIDTH`, 32: number of pins.
- `SYNC_STAGES`, 2: synchroniser flops per pin; legal range ≥2.
- `CNT_W`, 8: debounce counter width.
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk_i`  in  1: system clock; all state updates on its rising edge.
- `rst_ni`  in  1: synchronous active-low reset, sampled on `clk_i` rising edge.
- `pins_i`  in  WIDTH: raw asynchronous pad levels.
- `filter_en_i`  in  WIDTH: per-pin debounce enable; 0 means bypass, with the synchronised level passed straight to the filtered register.
- `debounce_len_i`  in  CNT_W: stability threshold; quasi-static, may change at any time.
- `pins_o`  out  WIDTH: filtered level.
- `rise_o`  out  WIDTH: one-cycle pulse on an accepted 0→1 change.
- `fall_o`  out  WIDTH: one-cycle pulse on an accepted 1→0 change.
- `changed_o`  out  1: OR of all `rise_o | fall_o`.
- `glitch_cnt_o`  out  16: rejected-glitch counter (see Configuration).

## Operation
- **Synchroniser:** a per-pin shift chain of `SYNC_STAGES` flops; `sync` is the last stage.
- **Per-pin state:**
  - filtered flop `filt`, which drives `pins_o`;
  - counter `cnt[CNT_W]`;
  - registered `rise`/`fall` flops.
- **Per-pin update each cycle, with debounce enabled:**
  - `sync == filt`: `cnt <= 0`, no event.
  - `sync != filt` and `cnt >= debounce_len_i`: `filt <= sync`, `cnt <= 0`, pulse `rise` or `fall` per the new level.
  - `sync != filt` and `cnt < debounce_len_i`: `cnt <= cnt + 1`.
- **Bypass (`filter_en_i[i]=0`):**
  - `filt <= sync` every cycle;
  - `cnt` held 0;
  - edges still pulse on every change.
- **Acceptance rule:** a change is accepted after `debounce_len_i+1` consecutive cycles of `sync` differing from `filt`.
  - `debounce_len_i = 0` accepts on the first differing cycle.
  - The counter cannot overflow: the compare is `>=` and the counter stops at the threshold.
- **Threshold lowered mid-count:** if `cnt` is already ≥ the new value, the change is accepted on the next differing cycle.
- **Threshold raised mid-count:** counting continues toward the new value.
- **Toggling `filter_en_i` mid-count:** disabling clears `cnt` that cycle and the bypass rule applies immediately. Enabling starts from `cnt=0`.
- **Reset:** `rst_ni=0` at a rising edge clears all synchroniser flops, `filt`, `cnt`, `rise`, `fall` and the glitch counter to 0. Reset has priority over every other update, including mid-count.

## Timing
- **Latency (debounce enabled):** a level on `pins_i` that is stable from edge k is visible on `pins_o` after edge k+`SYNC_STAGES`+`debounce_len_i`.
  - That is `SYNC_STAGES+debounce_len_i+1` edges counting edge k.
  - Example: 6 edges for the defaults with `debounce_len_i=3`.
- **Latency (bypass):** `SYNC_STAGES+1` edges.
- **Event pulses:** `rise_o`/`fall_o` are asserted in the same cycle that `pins_o` takes the new value, for exactly one cycle.
- **`changed_o`:** combinational OR of the registered pulses, so it has zero extra latency.
- **Reset values:**
  - all outputs are 0;
  - the first valid sample reaches `sync` `SYNC_STAGES` edges after reset release.
- **Pin-independence:** pins are fully independent; simultaneous events on any number of pins are all reported in the same cycle.

## Configuration
- `GPIO_IN_FILTER_GLITCH_STATS_EN` defined:
  - a glitch is counted when a pin with debounce enabled has `sync == filt` while `cnt != 0`, i.e. the candidate change is abandoned;
  - `glitch_cnt_o` increments by 1 per cycle in which at least one pin abandons a candidate change;
  - `glitch_cnt_o` saturates at 16'hFFFF.
- Macro undefined: the counter logic is absent and `glitch_cnt_o` is tied to 16'h0000.
- Filtering behaviour is identical in both builds.

## Test plan
- **Reset:** hold `rst_ni=0` while driving `pins_i=32'hFFFF_FFFF` → all outputs 0. After release, `pins_o` reaches 32'hFFFF_FFFF after exactly `2+len+1` edges, with `rise_o=32'hFFFF_FFFF` for one cycle and `changed_o=1`.
- **Latency:** `debounce_len_i=3`, all pins enabled, bit 5 steps 0→1 → `pins_o[5]` rises 6 edges later; `rise_o[5]` is a one-cycle pulse; no other bits toggle.
- **Glitch rejection:** `debounce_len_i=3`, bit 0 held high for 3 cycles then low → `pins_o[0]` stays 0 and no `rise_o[0]`. With the macro defined, `glitch_cnt_o` goes from 0 to 1.
- **Bypass:** `filter_en_i=32'h0`, `debounce_len_i=8'hFF`, `pins_i=32'hA5A5_5A5A` → `pins_o` matches after 3 edges. Then a one-cycle pulse on bit 3 appears on `pins_o[3]` for one cycle, with both `rise_o[3]` and `fall_o[3]` pulses.
- **Mid-count threshold change:** `debounce_len_i=10`, bit 7 changes, and after 5 differing cycles the threshold is set to 2 → accepted on the next cycle.
- **Reset mid-count:** `rst_ni` asserted during a count → `pins_o`, `cnt` and events cleared; no spurious pulse after release for inputs at 0.
